bcd_to_excess3_serial: RTL



---
 rtl/bcd_codes_pkg.sv | 15 +
 rtl/bcd_xs3_bit_fsm.sv | 44 ++++
 rtl/bcd_to_excess3_serial.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bcd_codes_pkg.sv
// Shared constants and types for the BCD / Excess-3 conversion blocks.
package bcd_codes_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] XS3_OFFSET = 4'd3;
    localparam logic [DIGIT_W-1:0] BCD_MAX    = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_xs3_bit_fsm.sv
// Carry-state Mealy adder: adds one addend bit per clock to a serial stream.
// The carry is dropped at each digit boundary so every digit wraps mod 16.
module bcd_xs3_bit_fsm
    import bcd_codes_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic bit_in,
    input  logic k,
    input  logic digit_last,
    output logic sum_out,
    output logic carry
);

    logic carry_nxt;

    // Carry state register
    always_ff @(posedge clk) begin
        if (rst) begin
            carry <= 1'b0;
        end else begin
            carry <= carry_nxt;
        end
    end

    // Next carry: majority of the three inputs, discarded at the digit boundary
    always_comb begin
        carry_nxt = carry;
        if (clr) begin
            carry_nxt = 1'b0;
        end else if (en) begin
            carry_nxt = digit_last ? 1'b0
                                   : ((bit_in & k) | (bit_in & carry) | (k & carry));
        end
    end

    // Mealy sum output
    always_comb begin
        sum_out = bit_in ^ k ^ carry;
    end

endmodule

// File: rtl/bcd_to_excess3_serial.sv
// Bit-serial packed BCD to Excess-3 converter with valid/ready on both sides.
// Optional macro BCD_XS3_ERR_CHECK_EN: flags input digits greater than 9 on out_err.
module bcd_to_excess3_serial
    import bcd_codes_pkg::*;
#(
    parameter int unsigned DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4*DIGITS-1:0]       in_bcd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*DIGITS-1:0]       out_xs3,
    output logic                      out_err
);

    localparam int unsigned W     = DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     sr;
    logic [W-1:0]     sr_shift;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             conv;
    logic             last_bit;
    logic             k;
    logic             digit_last;
    logic             sum;
    logic             carry;
    logic             in_ready_nxt;
    logic             out_valid_nxt;

    // Datapath decode: addend follows the 0011 pattern within each digit
    always_comb begin
        accept     = in_valid && in_ready;
        conv       = (state == CONV);
        k          = ~cnt[1];
        digit_last = &cnt[1:0];
        last_bit   = (cnt == CNT_LAST);
        sr_shift   = {sum, sr[W-1:1]};
    end

    bcd_xs3_bit_fsm u_bit_fsm (
        .clk        (clk),
        .rst        (rst),
        .en         (conv),
        .clr        (accept),
        .bit_in     (sr[0]),
        .k          (k),
        .digit_last (digit_last),
        .sum_out    (sum),
        .carry      (carry)
    );

    // Handshake FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = CONV;
            CONV:    if (last_bit)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the flags register with it
    always_comb begin
        in_ready_nxt  = (state_nxt == IDLE);
        out_valid_nxt = (state_nxt == DONE);
    end

    // Registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    // Shift register, bit counter and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            sr      <= '0;
            cnt     <= '0;
            out_xs3 <= '0;
        end else begin
            if (accept) begin
                sr  <= in_bcd;
                cnt <= '0;
            end else if (conv) begin
                sr  <= sr_shift;
                cnt <= cnt + CNT_W'(1);
                if (last_bit) begin
                    out_xs3 <= sr_shift;
                end
            end
        end
    end

`ifdef BCD_XS3_ERR_CHECK_EN
    logic bad_digit;

    // Any digit above 9 marks the word as invalid BCD
    always_comb begin
        bad_digit = 1'b0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (in_bcd[d*DIGIT_W +: DIGIT_W] > BCD_MAX) begin
                bad_digit = 1'b1;
            end
        end
    end

    // Error flag captured on accept, cleared on return to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            out_err <= 1'b0;
        end else if (accept) begin
            out_err <= bad_digit;
        end else if (state_nxt == IDLE) begin
            out_err <= 1'b0;
        end
    end
`else
    assign out_err = 1'b0;
`endif

endmodule
